// File: rtl/top.sv
// 5-stage in-order RV32I core (IF/ID/EX/MEM/WB) with internal byte memories im/dm and register file.
// Build macro FORWARDING_EN compiles in the EX bypass network; without it, RAW hazards stall in ID.

module bytemem #(
    parameter int MEM_BYTES = 65536,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0]    mem [0:MEM_BYTES-1];
    logic [AW-1:0] a1, a2, a3;

    // Byte lanes wrap modulo the memory size, so misaligned accesses just touch addr..addr+n-1.
    assign a1 = addr + AW'(1);
    assign a2 = addr + AW'(2);
    assign a3 = addr + AW'(3);
    assign rdata = {mem[a3], mem[a2], mem[a1], mem[addr]};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata[7:0];
            if (size != 2'd0) mem[a1] <= wdata[15:8];
            if (size[1]) begin
                mem[a2] <= wdata[23:16];
                mem[a3] <= wdata[31:24];
            end
        end
    end
endmodule

module rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end

    // Write-before-read: a WB write this cycle is visible to the ID read.
    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : (we && waddr == raddr1) ? wdata : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : (we && waddr == raddr2) ? wdata : registers[raddr2];
endmodule

module top #(
    parameter int          MEM_BYTES = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_OP = 7'h33;

    typedef struct packed { logic [31:0] pc; logic [31:0] ir; } ifid_t;
    typedef struct packed { logic [31:0] pc, ir, a, b; logic we, mr, mw; } idex_t;
    typedef struct packed { logic [31:0] res, sd; logic [4:0] rd; logic [2:0] f3; logic we, mr, mw; } exmem_t;
    typedef struct packed { logic [31:0] wd; logic [4:0] rd; logic we; } memwb_t;

    localparam ifid_t IFID_NOP = '{pc: 32'h0, ir: NOP};
    localparam idex_t IDEX_NOP = '{pc: 32'h0, ir: NOP, a: 32'h0, b: 32'h0, we: 1'b0, mr: 1'b0, mw: 1'b0};

    function automatic logic [31:0] imm_of(input logic [31:0] ir);
        case (ir[6:0])
            OP_LUI, OP_AUIPC: imm_of = {ir[31:12], 12'b0};
            OP_JAL:           imm_of = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OP_BR:            imm_of = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_ST:            imm_of = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default:          imm_of = {{21{ir[31]}}, ir[30:20]};
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] ir);
        case (ir[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_OP: writes_rd = (ir[11:7] != 5'd0);
            default: writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ir);
        case (ir[6:0])
            OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP: uses_rs1 = 1'b1;
            default: uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        uses_rs2 = (ir[6:0] == OP_BR) || (ir[6:0] == OP_ST) || (ir[6:0] == OP_OP);
    endfunction

    logic [31:0] pc, ir_f;
    ifid_t       ifid;
    idex_t       idex;
    exmem_t      exmem;
    memwb_t      memwb;

    bytemem #(.MEM_BYTES(MEM_BYTES)) im (
        .clk(clk), .we(1'b0), .size(2'd2), .addr(pc[AW-1:0]), .wdata(32'h0), .rdata(ir_f)
    );

    // ID: register read and hazard detection
    logic [4:0]  rs1_d, rs2_d;
    logic [31:0] rv1, rv2;
    logic        dep_ex, stall;

    assign rs1_d = ifid.ir[19:15];
    assign rs2_d = ifid.ir[24:20];

    rf regfile (
        .clk(clk), .rst(rst), .we(memwb.we), .waddr(memwb.rd), .wdata(memwb.wd),
        .raddr1(rs1_d), .raddr2(rs2_d), .rdata1(rv1), .rdata2(rv2)
    );

    assign dep_ex = idex.we && ((uses_rs1(ifid.ir) && rs1_d == idex.ir[11:7]) ||
                                (uses_rs2(ifid.ir) && rs2_d == idex.ir[11:7]));
`ifdef FORWARDING_EN
    assign stall = dep_ex && idex.mr;
`else
    logic dep_mem;
    assign dep_mem = exmem.we && ((uses_rs1(ifid.ir) && rs1_d == exmem.rd) ||
                                  (uses_rs2(ifid.ir) && rs2_d == exmem.rd));
    assign stall = dep_ex || dep_mem;
`endif

    // EX: operand select, ALU, branch resolution
    logic [31:0] a_x, b_x, imm_x, opb, alu, res_x, tgt;
    logic [6:0]  opc_x;
    logic [2:0]  f3_x;
    logic        taken, redirect;

`ifdef FORWARDING_EN
    always_comb begin
        a_x = idex.a;
        b_x = idex.b;
        if (memwb.we && memwb.rd == idex.ir[19:15]) a_x = memwb.wd;
        if (exmem.we && exmem.rd == idex.ir[19:15]) a_x = exmem.res;
        if (memwb.we && memwb.rd == idex.ir[24:20]) b_x = memwb.wd;
        if (exmem.we && exmem.rd == idex.ir[24:20]) b_x = exmem.res;
    end
`else
    assign a_x = idex.a;
    assign b_x = idex.b;
`endif

    always_comb begin
        opc_x = idex.ir[6:0];
        f3_x  = idex.ir[14:12];
        imm_x = imm_of(idex.ir);
        opb   = (opc_x == OP_OP) ? b_x : imm_x;
        alu   = 32'h0;
        case (f3_x)
            3'd0: alu = (opc_x == OP_OP && idex.ir[30]) ? a_x - opb : a_x + opb;
            3'd1: alu = a_x << opb[4:0];
            3'd2: alu = {31'b0, $signed(a_x) < $signed(opb)};
            3'd3: alu = {31'b0, a_x < opb};
            3'd4: alu = a_x ^ opb;
            3'd5: alu = idex.ir[30] ? $unsigned($signed(a_x) >>> opb[4:0]) : a_x >> opb[4:0];
            3'd6: alu = a_x | opb;
            3'd7: alu = a_x & opb;
            default: alu = 32'h0;
        endcase
        taken = 1'b0;
        case (f3_x)
            3'd0: taken = (a_x == b_x);
            3'd1: taken = (a_x != b_x);
            3'd4: taken = ($signed(a_x) < $signed(b_x));
            3'd5: taken = ($signed(a_x) >= $signed(b_x));
            3'd6: taken = (a_x < b_x);
            3'd7: taken = (a_x >= b_x);
            default: taken = 1'b0;
        endcase
        res_x = alu;
        case (opc_x)
            OP_LUI:          res_x = imm_x;
            OP_AUIPC:        res_x = idex.pc + imm_x;
            OP_JAL, OP_JALR: res_x = idex.pc + 32'd4;
            OP_LD, OP_ST:    res_x = a_x + imm_x;
            default:         res_x = alu;
        endcase
        redirect = (opc_x == OP_BR && taken) || opc_x == OP_JAL || opc_x == OP_JALR;
        tgt      = (opc_x == OP_JALR) ? ((a_x + imm_x) & ~32'd1) : idex.pc + imm_x;
    end

    // MEM: combinational load with sub-word extension; store commits at the edge
    logic [31:0] ld_raw, ld_val, wd_m;

    bytemem #(.MEM_BYTES(MEM_BYTES)) dm (
        .clk(clk), .we(exmem.mw && rst), .size(exmem.f3[1:0]), .addr(exmem.res[AW-1:0]),
        .wdata(exmem.sd), .rdata(ld_raw)
    );

    always_comb begin
        ld_val = ld_raw;
        case (exmem.f3)
            3'd0: ld_val = {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'd1: ld_val = {{16{ld_raw[15]}}, ld_raw[15:0]};
            3'd4: ld_val = {24'h0, ld_raw[7:0]};
            3'd5: ld_val = {16'h0, ld_raw[15:0]};
            default: ld_val = ld_raw;
        endcase
        wd_m = exmem.mr ? ld_val : exmem.res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_PC;
            ifid  <= IFID_NOP;
            idex  <= IDEX_NOP;
            exmem <= '0;
            memwb <= '0;
        end else begin
            exmem <= '{res: res_x, sd: b_x, rd: idex.ir[11:7], f3: f3_x,
                       we: idex.we, mr: idex.mr, mw: idex.mw};
            memwb <= '{wd: wd_m, rd: exmem.rd, we: exmem.we};
            if (redirect) begin
                pc   <= tgt;
                ifid <= IFID_NOP;
                idex <= IDEX_NOP;
            end else if (stall) begin
                idex <= IDEX_NOP;
            end else begin
                pc   <= pc + 32'd4;
                ifid <= '{pc: pc, ir: ir_f};
                idex <= '{pc: ifid.pc, ir: ifid.ir, a: rv1, b: rv2, we: writes_rd(ifid.ir),
                          mr: (ifid.ir[6:0] == OP_LD), mw: (ifid.ir[6:0] == OP_ST)};
            end
        end
    end
endmodule

// File: tb/tb_top.sv
// Directed bench for the RV32I pipeline: programs are assembled into im, results read back from dm.
module tb_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pa = 0;

    top #(.MEM_BYTES(65536), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    typedef struct { string name; int addr; logic [31:0] exp; } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(input int imm20, input int rd, input int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction

    task automatic emit(input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.im.mem[pa + k] = w[8*k +: 8];
        pa += 4;
    endtask

    function automatic logic [31:0] rdw(input int a);
        return {dut.dm.mem[a+3], dut.dm.mem[a+2], dut.dm.mem[a+1], dut.dm.mem[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            dut.im.mem[i] = 8'h00;
            dut.dm.mem[i] = 8'h00;
        end
        for (int i = 32'h9000; i < 32'h9100; i++) dut.dm.mem[i] = 8'hA5;
        {dut.dm.mem[32'h907B], dut.dm.mem[32'h907A], dut.dm.mem[32'h9079], dut.dm.mem[32'h9078]} = 32'h12345678;
        pa = 0;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.regfile.registers[i], 32'h0);
    endtask

    // Releases reset and counts rising edges until the 0xFF completion byte lands at 0xFFFC.
    task automatic run_until_done(input string tag, output int cyc);
        bit done;
        cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        done = (dut.dm.mem[16'hFFFC] == 8'hFF);
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            done = (dut.dm.mem[16'hFFFC] == 8'hFF);
        end
        check({tag, "_done"}, {31'b0, done}, 32'h1);
    endtask

    task automatic load_timing(input bit dependent);
        rst = 1'b0;
        #1;
        clear_mem();
        emit(u_t(9, 7, 'h37));                       // LUI x7,0x9
        emit(i_t(-1, 0, 0, 8, 'h13));                // ADDI x8,x0,-1
        emit(32'h0000_0013);
        emit(32'h0000_0013);
        emit(i_t('h78, 7, 2, 4, 'h03));              // LW x4,0x78(x7)
        emit(dependent ? i_t(1, 4, 0, 5, 'h13) : i_t(1, 0, 0, 5, 'h13));
        emit(s_t(4, 5, 7, 2));                       // SW x5,4(x7)
        emit(s_t(-4, 8, 0, 0));                      // SB x8,-4(x0)
        emit(j_t(0, 0));
    endtask

    initial begin
        int cyc, cyc_dep, cyc_ind, stall_exp;
`ifdef FORWARDING_EN
        stall_exp = 1;
`else
        stall_exp = 2;
`endif
        vecs = '{
            '{"alu_chain_sub", 32'h9000, 32'h0000_0005},
            '{"alu_chain_add", 32'h9020, 32'h0000_000A},
            '{"load_use",      32'h9004, 32'h1234_5679},
            '{"lb",            32'h9008, 32'hFFFF_FFFF},
            '{"lbu",           32'h900C, 32'h0000_00FF},
            '{"lh",            32'h9010, 32'hFFFF_F0FF},
            '{"lhu",           32'h9014, 32'h0000_F0FF},
            '{"beq_flush",     32'h9018, 32'h0000_0000},
            '{"bne_fallthru",  32'h9024, 32'h0000_0002},
            '{"jal_link",      32'h901C, 32'h0000_0104},
            '{"sub_body",      32'h9028, 32'h0000_0055},
            '{"jalr_flush",    32'h902C, 32'h0000_0000},
            '{"srai",          32'h9030, 32'hF808_1F0F},
            '{"slt",           32'h9034, 32'h0000_0001},
            '{"bltu_bge",      32'h9038, 32'h0000_0013},
            '{"auipc",         32'h903C, 32'h0000_1138}
        };

        clear_mem();
        emit(u_t(9, 7, 'h37));                       // LUI x7,0x9
        emit(i_t(5, 0, 0, 1, 'h13));                 // ADDI x1,x0,5
        emit(r_t(0, 1, 1, 0, 2));                    // ADD x2,x1,x1
        emit(r_t('h20, 1, 2, 0, 3));                 // SUB x3,x2,x1
        emit(s_t(0, 3, 7, 2));
        emit(s_t('h20, 2, 7, 2));
        emit(i_t('h78, 7, 2, 4, 'h03));              // LW x4
        emit(i_t(1, 4, 0, 5, 'h13));                 // ADDI x5,x4,1
        emit(s_t(4, 5, 7, 2));
        emit(u_t('h8081F, 9, 'h37));
        emit(i_t('hFF, 9, 0, 9, 'h13));              // x9 = 0x8081F0FF
        emit(s_t('h7C, 9, 7, 2));
        emit(i_t('h7C, 7, 0, 10, 'h03));             // LB
        emit(i_t('h7C, 7, 4, 11, 'h03));             // LBU
        emit(i_t('h7C, 7, 1, 12, 'h03));             // LH
        emit(i_t('h7C, 7, 5, 13, 'h03));             // LHU
        emit(s_t('h08, 10, 7, 2));
        emit(s_t('h0C, 11, 7, 2));
        emit(s_t('h10, 12, 7, 2));
        emit(s_t('h14, 13, 7, 2));
        emit(i_t(0, 0, 0, 6, 'h13));
        emit(b_t(12, 0, 0, 0));                      // BEQ x0,x0,+12
        emit(i_t(1, 6, 0, 6, 'h13));
        emit(i_t(1, 6, 0, 6, 'h13));
        emit(s_t('h18, 6, 7, 2));
        emit(b_t(12, 0, 0, 1));                      // BNE x0,x0,+12
        emit(i_t(1, 6, 0, 6, 'h13));
        emit(i_t(1, 6, 0, 6, 'h13));
        emit(s_t('h24, 6, 7, 2));
        pa = 'h100;                                  // zero-filled gap executes as unknown-opcode NOPs
        emit(j_t('h100, 1));                         // JAL x1,0x200
        emit(s_t('h1C, 1, 7, 2));
        emit(s_t('h28, 14, 7, 2));
        emit(s_t('h2C, 15, 7, 2));
        emit(i_t('h404, 9, 5, 16, 'h13));            // SRAI x16,x9,4
        emit(r_t(0, 0, 9, 2, 17));                   // SLT x17,x9,x0
        emit(s_t('h30, 16, 7, 2));
        emit(s_t('h34, 17, 7, 2));
        emit(i_t(3, 0, 0, 18, 'h13));
        emit(b_t(8, 9, 0, 6));                       // BLTU x0,x9,+8 (taken)
        emit(i_t(4, 18, 0, 18, 'h13));
        emit(b_t(8, 0, 9, 5));                       // BGE x9,x0,+8 (not taken)
        emit(i_t(16, 18, 0, 18, 'h13));
        emit(s_t('h38, 18, 7, 2));
        emit(u_t(1, 19, 'h17));                      // AUIPC x19,1 at 0x138
        emit(s_t('h3C, 19, 7, 2));
        emit(i_t(-1, 0, 0, 8, 'h13));
        emit(s_t(-4, 8, 0, 0));                      // SB 0xFF -> 0xFFFC
        emit(j_t(0, 0));
        pa = 'h200;
        emit(i_t('h55, 0, 0, 14, 'h13));
        emit(i_t(0, 1, 0, 0, 'h67));                 // JALR x0,0(x1)
        emit(i_t(1, 0, 0, 15, 'h13));
        emit(i_t(2, 0, 0, 15, 'h13));

        dut.regfile.registers[5] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", dut.pc, 32'h0);
        check_regs_zero("reset");

        run_until_done("main", cyc);
        for (int i = 0; i < 16; i++) check(vecs[i].name, rdw(vecs[i].addr), vecs[i].exp);
        check("done_byte", {24'h0, dut.dm.mem[16'hFFFC]}, 32'h0000_00FF);

        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrun_pc", dut.pc, 32'h0);
        check("midrun_memw", {31'b0, dut.exmem.mw}, 32'h0);
        check_regs_zero("midrun");
        check("midrun_mem_kept", rdw(32'h9000), 32'h0000_0005);

        load_timing(1'b1);
        run_until_done("dep", cyc_dep);
        check("dep_result", rdw(32'h9004), 32'h1234_5679);
        load_timing(1'b0);
        run_until_done("indep", cyc_ind);
        check("indep_result", rdw(32'h9004), 32'h0000_0001);
        check("loaduse_stall_cycles", cyc_dep - cyc_ind, stall_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
